// File: rtl/cr_xp10_decomp_hufd_tbl_mgr.sv
// Round-robin multi-bank Huffman table manager between htf (table build) and sdd (symbol decode).
// Optional flush logic is enabled by defining CR_XP10_DECOMP_HUFD_TBL_MGR_FLUSH_EN.
module cr_xp10_decomp_hufd_tbl_mgr #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned FMT_W     = 4,
    parameter int unsigned INFO_W    = 16,
    parameter int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              htf_mgr_complete_valid,
    input  logic [FMT_W-1:0]  htf_mgr_complete_fmt,
    input  logic [INFO_W-1:0] htf_mgr_complete_info,
    input  logic              htf_mgr_complete_error,
    output logic              mgr_htf_wr_avail,
    output logic [BANK_W-1:0] mgr_htf_wr_bank,
    output logic              mgr_sdd_rd_valid,
    output logic [BANK_W-1:0] mgr_sdd_rd_bank,
    output logic [FMT_W-1:0]  mgr_sdd_rd_fmt,
    output logic [INFO_W-1:0] mgr_sdd_rd_info,
    output logic              mgr_sdd_rd_error,
    input  logic              sdd_mgr_rd_ready,
    input  logic              sdd_mgr_release,
    input  logic              mgr_flush,
    output logic [BANK_W:0]   mgr_occupancy,
    output logic              mgr_overflow_err,
    output logic              mgr_underflow_err
);

    localparam logic [BANK_W-1:0] LAST_BANK   = BANK_W'(NUM_BANKS - 1);
    localparam logic [BANK_W:0]   NUM_BANKS_C = (BANK_W + 1)'(NUM_BANKS);

    logic [BANK_W-1:0] fill_ptr;
    logic [BANK_W-1:0] rd_ptr;
    logic [BANK_W-1:0] rel_ptr;
    logic [BANK_W:0]   ready_cnt;
    logic [BANK_W:0]   active_cnt;
    logic [BANK_W:0]   occ;
    logic              overflow_err;
    logic              underflow_err;

    logic [FMT_W-1:0]  fmt_mem  [NUM_BANKS];
    logic [INFO_W-1:0] info_mem [NUM_BANKS];
    logic              err_mem  [NUM_BANKS];

    logic avail;
    logic rd_valid;
    logic do_complete;
    logic do_pop;
    logic do_release;
    logic flush;

    function automatic logic [BANK_W-1:0] next_ptr(input logic [BANK_W-1:0] p);
        return (p == LAST_BANK) ? '0 : p + BANK_W'(1);
    endfunction

`ifdef CR_XP10_DECOMP_HUFD_TBL_MGR_FLUSH_EN
    assign flush = mgr_flush;
`else
    logic unused_flush;
    assign unused_flush = mgr_flush;
    assign flush        = 1'b0;
`endif

    assign occ         = ready_cnt + active_cnt;
    assign avail       = occ < NUM_BANKS_C;
    assign rd_valid    = ready_cnt != '0;
    assign do_complete = htf_mgr_complete_valid & avail;
    assign do_pop      = rd_valid & sdd_mgr_rd_ready;
    assign do_release  = sdd_mgr_release & (active_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_ptr      <= '0;
            rd_ptr        <= '0;
            rel_ptr       <= '0;
            ready_cnt     <= '0;
            active_cnt    <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            // Error flags deliberately survive a flush.
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            rel_ptr    <= '0;
            ready_cnt  <= '0;
            active_cnt <= '0;
        end else begin
            if (do_complete) fill_ptr <= next_ptr(fill_ptr);
            if (do_pop)      rd_ptr   <= next_ptr(rd_ptr);
            if (do_release)  rel_ptr  <= next_ptr(rel_ptr);
            ready_cnt  <= ready_cnt + {{BANK_W{1'b0}}, do_complete}
                                    - {{BANK_W{1'b0}}, do_pop};
            active_cnt <= active_cnt + {{BANK_W{1'b0}}, do_pop}
                                     - {{BANK_W{1'b0}}, do_release};
            if (htf_mgr_complete_valid && !avail)        overflow_err  <= 1'b1;
            if (sdd_mgr_release && (active_cnt == '0))   underflow_err <= 1'b1;
        end
    end

    // Metadata needs no reset: it is only visible while its bank is READY.
    always_ff @(posedge clk) begin
        if (do_complete && !flush) begin
            fmt_mem[fill_ptr]  <= htf_mgr_complete_fmt;
            info_mem[fill_ptr] <= htf_mgr_complete_info;
            err_mem[fill_ptr]  <= htf_mgr_complete_error;
        end
    end

    assign mgr_htf_wr_avail  = avail;
    assign mgr_htf_wr_bank   = fill_ptr;
    assign mgr_sdd_rd_valid  = rd_valid;
    assign mgr_sdd_rd_bank   = rd_ptr;
    assign mgr_sdd_rd_fmt    = rd_valid ? fmt_mem[rd_ptr]  : '0;
    assign mgr_sdd_rd_info   = rd_valid ? info_mem[rd_ptr] : '0;
    assign mgr_sdd_rd_error  = rd_valid ? err_mem[rd_ptr]  : 1'b0;
    assign mgr_occupancy     = occ;
    assign mgr_overflow_err  = overflow_err;
    assign mgr_underflow_err = underflow_err;

endmodule

// File: tb/tb_cr_xp10_decomp_hufd_tbl_mgr.sv
// Scoreboard bench for cr_xp10_decomp_hufd_tbl_mgr: a queue-based table model plus a
// negedge monitor that checks every presented bank and the status outputs each cycle.
module tb_cr_xp10_decomp_hufd_tbl_mgr;

    localparam int NB     = 3;
    localparam int FMT_W  = 4;
    localparam int INFO_W = 16;
    localparam int BW     = $clog2(NB);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              htf_mgr_complete_valid;
    logic [FMT_W-1:0]  htf_mgr_complete_fmt;
    logic [INFO_W-1:0] htf_mgr_complete_info;
    logic              htf_mgr_complete_error;
    logic              mgr_htf_wr_avail;
    logic [BW-1:0]     mgr_htf_wr_bank;
    logic              mgr_sdd_rd_valid;
    logic [BW-1:0]     mgr_sdd_rd_bank;
    logic [FMT_W-1:0]  mgr_sdd_rd_fmt;
    logic [INFO_W-1:0] mgr_sdd_rd_info;
    logic              mgr_sdd_rd_error;
    logic              sdd_mgr_rd_ready;
    logic              sdd_mgr_release;
    logic              mgr_flush;
    logic [BW:0]       mgr_occupancy;
    logic              mgr_overflow_err;
    logic              mgr_underflow_err;

    cr_xp10_decomp_hufd_tbl_mgr #(
        .NUM_BANKS(NB),
        .FMT_W    (FMT_W),
        .INFO_W   (INFO_W)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .htf_mgr_complete_valid (htf_mgr_complete_valid),
        .htf_mgr_complete_fmt   (htf_mgr_complete_fmt),
        .htf_mgr_complete_info  (htf_mgr_complete_info),
        .htf_mgr_complete_error (htf_mgr_complete_error),
        .mgr_htf_wr_avail       (mgr_htf_wr_avail),
        .mgr_htf_wr_bank        (mgr_htf_wr_bank),
        .mgr_sdd_rd_valid       (mgr_sdd_rd_valid),
        .mgr_sdd_rd_bank        (mgr_sdd_rd_bank),
        .mgr_sdd_rd_fmt         (mgr_sdd_rd_fmt),
        .mgr_sdd_rd_info        (mgr_sdd_rd_info),
        .mgr_sdd_rd_error       (mgr_sdd_rd_error),
        .sdd_mgr_rd_ready       (sdd_mgr_rd_ready),
        .sdd_mgr_release        (sdd_mgr_release),
        .mgr_flush              (mgr_flush),
        .mgr_occupancy          (mgr_occupancy),
        .mgr_overflow_err       (mgr_overflow_err),
        .mgr_underflow_err      (mgr_underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bank;
        int fmt;
        int info;
        int err;
    } tbl_t;

    // Tables built but not yet handed to sdd, oldest first.
    tbl_t exp_q[$];
    int   m_ready  = 0;
    int   m_active = 0;
    int   m_fill   = 0;
    int   m_ovf    = 0;
    int   m_unf    = 0;
    int   tests    = 0;
    int   fails    = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready  = 0;
        m_active = 0;
        m_fill   = 0;
        exp_q.delete();
    endtask

    // Applies the inputs the DUT sampled on this edge to the model.
    task automatic model_apply();
        bit acc;
        bit pop;
        bit rel;
        acc = (m_ready + m_active) < NB;
        pop = (m_ready != 0) && sdd_mgr_rd_ready;
        rel = m_active != 0;
`ifdef CR_XP10_DECOMP_HUFD_TBL_MGR_FLUSH_EN
        if (mgr_flush) begin
            model_reset();
            return;
        end
`endif
        if (htf_mgr_complete_valid) begin
            if (acc) begin
                exp_q.push_back('{m_fill, int'(htf_mgr_complete_fmt),
                                  int'(htf_mgr_complete_info), int'(htf_mgr_complete_error)});
                m_fill = (m_fill + 1) % NB;
                m_ready++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) begin
            m_ready--;
            m_active++;
        end
        if (sdd_mgr_release) begin
            if (rel) m_active--;
            else     m_unf = 1;
        end
    endtask

    task automatic step(input bit c, input int f, input int i, input bit e,
                        input bit p, input bit r, input bit fl);
        htf_mgr_complete_valid = c;
        htf_mgr_complete_fmt   = FMT_W'(f);
        htf_mgr_complete_info  = INFO_W'(i);
        htf_mgr_complete_error = e;
        sdd_mgr_rd_ready       = p;
        sdd_mgr_release        = r;
        mgr_flush              = fl;
        @(posedge clk);
        if (rst_n) model_apply();
        #1;
    endtask

    task automatic clear_inputs();
        htf_mgr_complete_valid = 1'b0;
        htf_mgr_complete_fmt   = '0;
        htf_mgr_complete_info  = '0;
        htf_mgr_complete_error = 1'b0;
        sdd_mgr_rd_ready       = 1'b0;
        sdd_mgr_release        = 1'b0;
        mgr_flush              = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        m_ovf = 0;
        m_unf = 0;
        #1;
        chk("rst_rd_bank", mgr_sdd_rd_bank, 0);
        chk("rst_rd_fmt", mgr_sdd_rd_fmt, 0);
        chk("rst_rd_info", mgr_sdd_rd_info, 0);
        chk("rst_rd_error", mgr_sdd_rd_error, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        chk("avail", mgr_htf_wr_avail, int'((m_ready + m_active) < NB));
        chk("wr_bank", mgr_htf_wr_bank, m_fill);
        chk("occupancy", mgr_occupancy, m_ready + m_active);
        chk("overflow_err", mgr_overflow_err, m_ovf);
        chk("underflow_err", mgr_underflow_err, m_unf);
        chk("rd_valid", mgr_sdd_rd_valid, int'(m_ready != 0));
        if (m_ready != 0) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                chk("rd_bank", mgr_sdd_rd_bank, exp_q[0].bank);
                chk("rd_fmt", mgr_sdd_rd_fmt, exp_q[0].fmt);
                chk("rd_info", mgr_sdd_rd_info, exp_q[0].info);
                chk("rd_error", mgr_sdd_rd_error, exp_q[0].err);
                if (sdd_mgr_rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First table, pop it, second table lands in bank 1; then hold off sdd.
        step(1, 3, 'h1234, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 5, 'habcd, 1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Fill every bank, overflow, then underflow on an empty active set.
        reset_dut();
        for (int k = 0; k < NB; k++) step(1, k + 1, 'h100 + k, 0, 0, 0, 0);
        step(1, 9, 'hdead, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // 1 READY + 1 ACTIVE, then simultaneous complete/pop/release across the wrap.
        reset_dut();
        step(1, 1, 'h11, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 2, 'h22, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 4 + k, 'h40 + k, k[0], 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset with all banks occupied.
        for (int k = 0; k < NB; k++) step(1, k, 'h300 + k, 0, 0, 0, 0);
        reset_dut();
        step(0, 0, 0, 0, 0, 0, 0);

        // Flush coinciding with a complete, with a sticky flag already set.
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 7, 'h777, 0, 0, 0, 0);
        step(1, 8, 'h888, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_dut();
            end else begin
                step($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1),
                     $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 49) == 0);
            end
        end

        clear_inputs();
        step(0, 0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
